// File: rtl/shared_mem_arbiter.sv
// Arbiter for one single-port shared RAM: NUM_CORES round-robin core ports plus a
// prioritised VGA read port, limited by a starvation guard. Fixed IDLE/ISSUE/RESP access.
module shared_mem_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int VGA_MAX_RUN = 4,
  localparam int PTR_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int RUN_W      = $clog2(VGA_MAX_RUN + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  input  logic                        vga_req,
  input  logic [ADDR_W-1:0]           vga_addr,
  output logic                        vga_ack,
  output logic [DATA_W-1:0]           vga_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [1:0]                  dbg_state,
  output logic [PTR_W-1:0]            dbg_rr_ptr,
  output logic [RUN_W-1:0]            dbg_vga_run
);

  // Handshake: a requester raises req (with we/addr/wdata stable) and holds it until
  // its one-cycle ack; only IDLE samples requests, so changes made during ISSUE/RESP
  // are seen in the following IDLE cycle. Reads return data in the ack cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr;
  logic [RUN_W-1:0] vga_run;
  logic             grant_vga;
  logic [PTR_W-1:0] grant_id;

  logic             core_pending;
  logic             core_found;
  logic [PTR_W-1:0] core_sel;
  logic [PTR_W-1:0] cand;
  int               idx;
  logic             vga_wins;
  logic             any_req;

  assign dbg_state   = state;
  assign dbg_rr_ptr  = rr_ptr;
  assign dbg_vga_run = vga_run;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    idx        = 0;
    cand       = '0;
    core_found = 1'b0;
    core_sel   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = PTR_W'(idx);
      if (!core_found && core_req[cand]) begin
        core_found = 1'b1;
        core_sel   = cand;
      end
    end
  end

  assign core_pending = |core_req;
  assign vga_wins     = vga_req && (!core_pending || (vga_run < RUN_W'(VGA_MAX_RUN)));
  assign any_req      = vga_req || core_found;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_ISSUE;
      S_ISSUE: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // The mem_* registers double as the latched grant (we/addr/wdata).
  always_ff @(posedge clk) begin
    if (reset) begin
      core_ack   <= '0;
      vga_ack    <= 1'b0;
      core_rdata <= '0;
      vga_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      vga_run    <= '0;
      grant_vga  <= 1'b0;
      grant_id   <= '0;
    end else begin
      core_ack <= '0;
      vga_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            grant_vga <= vga_wins;
            grant_id  <= core_sel;
            if (vga_wins) begin
              mem_we    <= 1'b0;
              mem_addr  <= vga_addr;
              mem_wdata <= '0;
              if (!core_pending)
                vga_run <= '0;
              else if (vga_run != RUN_W'(VGA_MAX_RUN))
                vga_run <= vga_run + 1'b1;
            end else begin
              mem_we    <= core_we[core_sel];
              mem_addr  <= core_addr[core_sel*ADDR_W +: ADDR_W];
              mem_wdata <= core_wdata[core_sel*DATA_W +: DATA_W];
              vga_run   <= '0;
              rr_ptr    <= (core_sel == PTR_W'(NUM_CORES - 1)) ? '0 : core_sel + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (grant_vga) begin
            vga_ack   <= 1'b1;
            vga_rdata <= mem_rdata;
          end else begin
            core_ack[grant_id] <= 1'b1;
            if (!mem_we) core_rdata <= mem_rdata;
          end
        end
        S_RESP: begin
          busy <= 1'b0;
        end
        default: begin
          mem_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a small RAM model plus hand-computed expectations
// for single access, round-robin, VGA starvation guard, write/read, VGA-only and reset abort.
module tb_shared_mem_arbiter;

  localparam int N     = 4;
  localparam int A     = 8;
  localparam int D     = 8;
  localparam int RUN_W = 3;
  localparam int PTR_W = 2;

  // clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   core_req = '0;
  logic [N-1:0]   core_we = '0;
  logic [N*A-1:0] core_addr = '0;
  logic [N*D-1:0] core_wdata = '0;
  logic [N-1:0]   core_ack;
  logic [D-1:0]   core_rdata;
  logic           vga_req = 1'b0;
  logic [A-1:0]   vga_addr = '0;
  logic           vga_ack;
  logic [D-1:0]   vga_rdata;
  logic           mem_en, mem_we;
  logic [A-1:0]   mem_addr;
  logic [D-1:0]   mem_wdata;
  logic [D-1:0]   mem_rdata;
  logic           busy;
  logic [1:0]     dbg_state;
  logic [PTR_W-1:0] dbg_rr_ptr;
  logic [RUN_W-1:0] dbg_vga_run;

  shared_mem_arbiter #(.NUM_CORES(N), .ADDR_W(A), .DATA_W(D), .VGA_MAX_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_vga_run(dbg_vga_run)
  );

  // RAM model: write on the edge closing the mem_en cycle, read data captured by the
  // arbiter on that same edge.
  logic [D-1:0] mem [256];
  logic         pre_we = 1'b0;
  logic [A-1:0] pre_addr = '0;
  logic [D-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  // Requester protocol monitor: req may only fall after its ack.
  logic [N-1:0] held = '0;
  always @(posedge clk) begin
    if (reset) begin
      held <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        assert (!(held[i] && !core_req[i] && !core_ack[i])) else begin
          errors++;
          $error("FAIL req_drop core %0d observed=0 expected=1", i);
        end
      end
      held <= core_req & ~core_ack;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [D-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [A-1:0] a, input logic [D-1:0] wd);
    core_we[i]            = we;
    core_addr[i*A +: A]   = a;
    core_wdata[i*D +: D]  = wd;
  endtask

  // Called in the IDLE cycle whose closing edge grants core g.
  task automatic core_access(input int g, input logic [A-1:0] a, input logic we,
                             input logic [D-1:0] wd, input logic [D-1:0] rd, input logic drop);
    step();
    chk($sformatf("c%0d_iss_en", g), 32'(mem_en), 32'd1);
    chk($sformatf("c%0d_iss_we", g), 32'(mem_we), 32'(we));
    chk($sformatf("c%0d_iss_addr", g), 32'(mem_addr), 32'(a));
    if (we) chk($sformatf("c%0d_iss_wdata", g), 32'(mem_wdata), 32'(wd));
    chk($sformatf("c%0d_iss_busy", g), 32'(busy), 32'd1);
    chk($sformatf("c%0d_iss_noack", g), 32'({vga_ack, core_ack}), 32'd0);
    step();
    chk($sformatf("c%0d_ack", g), 32'(core_ack), 32'(1 << g));
    chk($sformatf("c%0d_vga_quiet", g), 32'(vga_ack), 32'd0);
    chk($sformatf("c%0d_resp_en", g), 32'(mem_en), 32'd0);
    if (!we) chk($sformatf("c%0d_rdata", g), 32'(core_rdata), 32'(rd));
    if (drop) core_req[g] = 1'b0;
    step();
    chk($sformatf("c%0d_idle_busy", g), 32'(busy), 32'd0);
    chk($sformatf("c%0d_idle_rr", g), 32'(dbg_rr_ptr), 32'((g + 1) % N));
  endtask

  task automatic vga_access(input logic [A-1:0] a, input logic [D-1:0] rd,
                            input int exp_run, input logic drop);
    step();
    chk("v_iss_en", 32'(mem_en), 32'd1);
    chk("v_iss_we", 32'(mem_we), 32'd0);
    chk("v_iss_addr", 32'(mem_addr), 32'(a));
    step();
    chk("v_ack", 32'(vga_ack), 32'd1);
    chk("v_core_quiet", 32'(core_ack), 32'd0);
    chk("v_rdata", 32'(vga_rdata), 32'(rd));
    if (drop) vga_req = 1'b0;
    step();
    chk("v_idle_busy", 32'(busy), 32'd0);
    chk("v_run", 32'(dbg_vga_run), 32'(exp_run));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and RAM preload
    preload(8'h10, 8'hA5);
    preload(8'h20, 8'hFF);
    for (int k = 0; k < 8; k++) preload(8'(8'h40 + k), 8'(8'h80 + k));
    for (int k = 0; k < 4; k++) preload(8'(8'h50 + k), 8'(8'h60 + k));
    chk("rst_core_ack", 32'(core_ack), 32'd0);
    chk("rst_vga_ack", 32'(vga_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_core_rdata", 32'(core_rdata), 32'd0);
    chk("rst_vga_rdata", 32'(vga_rdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_rr", 32'(dbg_rr_ptr), 32'd0);
    chk("rst_run", 32'(dbg_vga_run), 32'd0);
    reset = 1'b0;
    step();

    // single read by core 2
    set_core(2, 1'b0, 8'h10, 8'h00);
    core_req = 4'b0100;
    core_access(2, 8'h10, 1'b0, 8'h00, 8'hA5, 1'b1);

    // write by core 0 (rr 3 -> wraps to core 0), then read back by core 3
    set_core(0, 1'b1, 8'h20, 8'h3C);
    core_req = 4'b0001;
    core_access(0, 8'h20, 1'b1, 8'h3C, 8'h00, 1'b1);
    set_core(3, 1'b0, 8'h20, 8'h00);
    core_req = 4'b1000;
    core_access(3, 8'h20, 1'b0, 8'h00, 8'h3C, 1'b1);

    // round-robin with all cores requesting; second lap retires each core
    for (int i = 0; i < N; i++) set_core(i, 1'b0, 8'(8'h50 + i), 8'h00);
    core_req = 4'b1111;
    for (int k = 0; k < 8; k++)
      core_access(k % N, 8'(8'h50 + (k % N)), 1'b0, 8'h00, 8'(8'h60 + (k % N)), k >= 4);

    // VGA starvation guard against core 1
    vga_addr = 8'h40;
    vga_req  = 1'b1;
    core_req = 4'b0010;
    for (int k = 1; k <= 4; k++) vga_access(8'h40, 8'h80, k, 1'b0);
    core_access(1, 8'h51, 1'b0, 8'h00, 8'h61, 1'b1);
    chk("guard_run_clear", 32'(dbg_vga_run), 32'd0);
    vga_access(8'h40, 8'h80, 0, 1'b1);

    // VGA alone, incrementing addresses
    for (int k = 0; k < 8; k++) begin
      vga_addr = 8'(8'h40 + k);
      vga_req  = 1'b1;
      vga_access(8'(8'h40 + k), 8'(8'h80 + k), 0, k == 7);
    end

    // reset during ISSUE of core 2 (rr_ptr=2); core 1 must win afterwards
    set_core(1, 1'b0, 8'h51, 8'h00);
    set_core(2, 1'b0, 8'h52, 8'h00);
    core_req = 4'b0110;
    step();
    chk("ra_iss_en", 32'(mem_en), 32'd1);
    chk("ra_iss_addr", 32'(mem_addr), 32'h52);
    reset = 1'b1;
    step();
    chk("ra_core_ack", 32'(core_ack), 32'd0);
    chk("ra_mem_en", 32'(mem_en), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_mem_addr", 32'(mem_addr), 32'd0);
    chk("ra_rr", 32'(dbg_rr_ptr), 32'd0);
    chk("ra_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    core_access(1, 8'h51, 1'b0, 8'h00, 8'h61, 1'b1);
    core_access(2, 8'h52, 1'b0, 8'h00, 8'h62, 1'b1);
    chk("end_state", 32'(dbg_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Arbitrates one single-port shared data memory between NUM_CORES compute cores and the VGA scan-out reader.
- Sits between the cores' load/store ports, the VGA read port and the shared framebuffer/data RAM. It runs alongside the task scheduler.
- Cores are served round-robin. VGA has priority, bounded by a starvation guard so cores keep progressing during scan-out.
- One access at a time; fixed 3-cycle request-to-ack protocol.

Parameters:
- NUM_CORES, 4, number of core requesters (≥2).
- ADDR_W, 8, shared memory address width.
- DATA_W, 8, data width.
- VGA_MAX_RUN, 4, max consecutive VGA grants while any core request is pending.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request level. Held until the matching ack.
- core_we  in  NUM_CORES  per-core write enable (1=write, 0=read). Stable while req is high.
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed write data.
- core_ack  out  NUM_CORES  one-hot, 1-cycle completion pulse.
- core_rdata  out  DATA_W  read data, valid in the core_ack cycle.
- vga_req  in  1  VGA read request level.
- vga_addr  in  ADDR_W  VGA read address.
- vga_ack  out  1  1-cycle completion pulse.
- vga_rdata  out  DATA_W  read data, valid with vga_ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, 1 cycle after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset values:
  - core_ack=0, vga_ack=0, mem_en=0, mem_we=0, busy=0.
  - mem_addr, mem_wdata, core_rdata, vga_rdata = 0.
  - FSM=IDLE, rr_ptr=0, vga_run=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner at the clock edge and go to ISSUE.
  - Latch into the grant register: grant id, we, addr, wdata.
- Winner selection:
  - VGA wins if vga_req=1 and (no core_req pending, or vga_run < VGA_MAX_RUN).
  - Otherwise the winner is the first core i with core_req[i]=1, searching from rr_ptr upward with wrap modulo NUM_CORES.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/addr/wdata driven from the latched grant.
  - mem_we is forced to 0 for a VGA grant.
  - Next state: RESP.
- RESP (1 cycle):
  - Assert the ack of the granted requester.
  - Route mem_rdata to core_rdata or vga_rdata. Writes also ack, with rdata don't-care.
  - mem_en=0. Next state: IDLE.
- Requester rule: the requester samples ack at the end of the RESP cycle and deasserts or changes req from the next cycle. The IDLE cycle after RESP therefore sees the updated req.
- Timing: request seen in IDLE cycle t → mem_en in t+1 → ack in t+2. Minimum spacing between grants is 3 cycles.
- rr_ptr update on a core grant to core g: rr_ptr ← (g+1) mod NUM_CORES. Wrap from NUM_CORES-1 to 0. rr_ptr is unchanged on VGA grants.
- vga_run update:
  - VGA grant with a core request pending: vga_run+1, saturating at VGA_MAX_RUN.
  - Any core grant: vga_run ← 0.
  - VGA grant with no core pending: vga_run stays 0.
- Requests that change while the FSM is in ISSUE or RESP are ignored; only IDLE samples requests.
- Simultaneous vga_req and all core_req every IDLE cycle: VGA gets VGA_MAX_RUN grants, then one core grant, repeating. Each core is served within NUM_CORES*(VGA_MAX_RUN+1) grants.
- Reset in ISSUE/RESP: the in-flight access is abandoned. No ack is issued, and mem_en is 0 from the next cycle.
- Dropping req before ack is illegal. The bench flags it as an assertion error.
- No combinational path from any input to any output.

Test Plan:
- Single read: core 2 reads addr 0x10, memory holds 0xA5 → mem_en in cycle t+1 with mem_addr=0x10, mem_we=0; core_ack=4'b0100 and core_rdata=0xA5 in t+2; busy high for 2 cycles.
- Round-robin: all 4 cores request continuously, no VGA → grant order 0,1,2,3,0. Each ack is 3 cycles after the previous; rr_ptr wraps 3→0.
- VGA starvation guard: vga_req and core_req=4'b0010 held, VGA_MAX_RUN=4 → 4 vga_acks, then core_ack[1], then vga_ack resumes with vga_run reset to 0.
- Write then read: core 0 writes 0x3C to 0x20, then core 3 reads 0x20 → mem_we=1 with wdata=0x3C on the first access; core 3 gets core_rdata=0x3C.
- VGA alone: vga_req held 8 accesses with incrementing addr, no cores → 8 vga_acks at 3-cycle spacing; vga_run stays 0; mem_we is never 1.
- Reset mid-access: reset asserted in ISSUE → no ack, and all outputs 0 next cycle. After release, a pending request from core 1 is granted ahead of core 2, because rr_ptr=0.
